// File: rtl/casez_pat_pkg.sv
// rtl/casez_pat_pkg.sv - shared states, class codes and pattern map for the casez pattern encoder
package casez_pat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DFLT  = 2'd3
    } state_e;

    localparam logic [1:0] CODE_Z0   = 2'd0;
    localparam logic [1:0] CODE_Z1   = 2'd1;
    localparam logic [1:0] CODE_Z4   = 2'd2;
    localparam logic [1:0] CODE_DFLT = 2'd3;

    localparam logic [3:0] PAT_0000      = 4'b0000;
    localparam logic [3:0] PAT_00Z1_BASE = 4'b0001;
    localparam logic [3:0] PAT_0100      = 4'b0100;

    // The 00z1 class leaves bit 1 free; dc_fill decides what is driven there.
    function automatic logic [3:0] map_code(input logic [1:0] code, input logic dc_fill);
        logic [3:0] pat;
        case (code)
            CODE_Z0: pat = PAT_0000;
            CODE_Z1: pat = PAT_00Z1_BASE | {2'b00, dc_fill, 1'b0};
            CODE_Z4: pat = PAT_0100;
            default: pat = PAT_0000;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/casez_dwell_counter.sv
// rtl/casez_dwell_counter.sv - clearable 4-bit dwell counter with terminal-count compare
module casez_dwell_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [3:0] limit_i,
    output logic       tc_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Clear wins over count so a state change always restarts the dwell at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/casez_pattern_encoder.sv
// rtl/casez_pattern_encoder.sv - handshake-driven pattern generator with setup/hold dwell timing
module casez_pattern_encoder
    import casez_pat_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 3,
    parameter int unsigned HOLD_CYC  = 3,
    parameter int unsigned DFLT_CYC  = 2,
    parameter logic        DC_FILL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [1:0] code,
    output logic       code_ready,
    output logic [3:0] pat_out,
    output logic       pat_valid,
    output logic       busy,
    output logic       dflt_pulse
);

    // Dwell counts must fit the 4-bit counter without wrapping.
    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("SETUP_CYC out of range 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("HOLD_CYC out of range 1..15");
    end
    if (DFLT_CYC < 1 || DFLT_CYC > 15) begin : g_bad_dflt
        $error("DFLT_CYC out of range 1..15");
    end

    localparam logic [3:0] SETUP_LIM = 4'(SETUP_CYC - 1);
    localparam logic [3:0] HOLD_LIM  = 4'(HOLD_CYC - 1);
    localparam logic [3:0] DFLT_LIM  = 4'(DFLT_CYC - 1);

    state_e     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [3:0] pat_q, pat_d;
    logic       pv_q, pv_d;
    logic       dflt_q, dflt_d;

    logic       cnt_clr;
    logic       cnt_en;
    logic [3:0] cnt_limit;
    logic       cnt_tc;

    casez_dwell_counter u_dwell (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (cnt_limit),
        .tc_o    (cnt_tc)
    );

    // The counter runs in every non-idle state; each exit clears it for the next phase.
    assign cnt_en = (state_q != ST_IDLE);

    // Next-state, dwell limit selection and output register updates.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        pat_d     = pat_q;
        pv_d      = pv_q;
        dflt_d    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_limit = 4'd0;
        case (state_q)
            ST_IDLE: begin
                if (code_valid) begin
                    code_d  = code;
                    cnt_clr = 1'b1;
                    state_d = (code == CODE_DFLT) ? ST_DFLT : ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_limit = SETUP_LIM;
                if (cnt_tc) begin
                    pat_d   = map_code(code_q, DC_FILL);
                    pv_d    = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                cnt_limit = HOLD_LIM;
                if (cnt_tc) begin
                    pv_d    = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DFLT: begin
                // Unmapped code: burn the default dwell, leave the pattern untouched.
                cnt_limit = DFLT_LIM;
                if (cnt_tc) begin
                    dflt_d  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= 2'd0;
            pat_q   <= PAT_0000;
            pv_q    <= 1'b0;
            dflt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pat_q   <= pat_d;
            pv_q    <= pv_d;
            dflt_q  <= dflt_d;
        end
    end

    assign code_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign pat_out    = pat_q;
    assign pat_valid  = pv_q;
    assign dflt_pulse = dflt_q;

endmodule

// File: tb/tb_casez_pattern_encoder.sv
// tb/tb_casez_pattern_encoder.sv - directed table-driven bench for casez_pattern_encoder
module tb_casez_pattern_encoder;

    logic       clk;
    logic       rst_n;
    logic       code_valid;
    logic [1:0] code;

    logic       code_ready_a, pat_valid_a, busy_a, dflt_pulse_a;
    logic [3:0] pat_out_a;
    logic       code_ready_b, pat_valid_b, busy_b, dflt_pulse_b;
    logic [3:0] pat_out_b;

    int checks = 0;
    int errors = 0;

    logic [3:0] prev_a;
    logic [3:0] prev_b;

    casez_pattern_encoder #(.SETUP_CYC(3), .HOLD_CYC(3), .DFLT_CYC(2), .DC_FILL(1'b1)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready_a),
        .pat_out    (pat_out_a),
        .pat_valid  (pat_valid_a),
        .busy       (busy_a),
        .dflt_pulse (dflt_pulse_a)
    );

    casez_pattern_encoder #(.SETUP_CYC(3), .HOLD_CYC(3), .DFLT_CYC(2), .DC_FILL(1'b0)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready_b),
        .pat_out    (pat_out_b),
        .pat_valid  (pat_valid_b),
        .busy       (busy_b),
        .dflt_pulse (dflt_pulse_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] code;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic       is_dflt;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit is_00z1(input logic [3:0] p);
        casez (p)
            4'b00z1: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until the DUT is ready, then clocks the accept edge.
    task automatic accept(input logic [1:0] c);
        int n;
        code       = c;
        code_valid = 1'b1;
        n = 0;
        while (!code_ready_a && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("accept_timeout", 0, 1);
        step();
        code_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        accept(v.code);
        chk($sformatf("v%0d_busy", idx), int'(busy_a), 1);
        chk($sformatf("v%0d_ready_low", idx), int'(code_ready_a), 0);
        if (!v.is_dflt) begin
            for (int k = 1; k <= 6; k++) begin
                step();
                chk($sformatf("v%0d_k%0d_pv", idx, k), int'(pat_valid_a), (k >= 3 && k <= 5) ? 1 : 0);
                chk($sformatf("v%0d_k%0d_pat_a", idx, k), int'(pat_out_a), (k >= 3) ? int'(v.exp_a) : int'(prev_a));
                chk($sformatf("v%0d_k%0d_pat_b", idx, k), int'(pat_out_b), (k >= 3) ? int'(v.exp_b) : int'(prev_b));
                if (k == 3 && v.code == 2'd1) begin
                    chk($sformatf("v%0d_casez_a", idx), int'(is_00z1(pat_out_a)), 1);
                    chk($sformatf("v%0d_casez_b", idx), int'(is_00z1(pat_out_b)), 1);
                end
                chk($sformatf("v%0d_k%0d_ready", idx, k), int'(code_ready_a), (k == 6) ? 1 : 0);
            end
            prev_a = v.exp_a;
            prev_b = v.exp_b;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                step();
                chk($sformatf("v%0d_k%0d_dflt", idx, k), int'(dflt_pulse_a), (k == 2) ? 1 : 0);
                chk($sformatf("v%0d_k%0d_pv", idx, k), int'(pat_valid_a), 0);
                chk($sformatf("v%0d_k%0d_pat_a", idx, k), int'(pat_out_a), int'(prev_a));
                if (k == 2) chk($sformatf("v%0d_ready", idx), int'(code_ready_a), 1);
            end
        end
    endtask

    initial begin
        int  second_k;
        int  rises;
        logic prev_busy;
        bit  saw_valid;

        vecs[0] = '{code: 2'd0, exp_a: 4'b0000, exp_b: 4'b0000, is_dflt: 1'b0};
        vecs[1] = '{code: 2'd1, exp_a: 4'b0011, exp_b: 4'b0001, is_dflt: 1'b0};
        vecs[2] = '{code: 2'd2, exp_a: 4'b0100, exp_b: 4'b0100, is_dflt: 1'b0};
        vecs[3] = '{code: 2'd3, exp_a: 4'b0000, exp_b: 4'b0000, is_dflt: 1'b1};

        rst_n      = 1'b0;
        code_valid = 1'b0;
        code       = 2'd0;
        prev_a     = 4'b0000;
        prev_b     = 4'b0000;
        step();
        step();
        chk("rst_pat", int'(pat_out_a), 0);
        chk("rst_pv", int'(pat_valid_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_ready", int'(code_ready_a), 1);
        chk("rst_dflt", int'(dflt_pulse_a), 0);
        #3 rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            run_vec(i);
            step();
        end

        // Back-to-back: code 1 then code 2 with code_valid held high throughout.
        code       = 2'd1;
        code_valid = 1'b1;
        step();
        code       = 2'd2;
        chk("b2b_first_busy", int'(busy_a), 1);
        second_k  = 0;
        prev_busy = busy_a;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 3) chk("b2b_pat1", int'(pat_out_a), 4'b0011);
            if (busy_a && !prev_busy && second_k == 0) begin
                second_k   = k;
                code_valid = 1'b0;
            end
            if (second_k != 0 && k == second_k + 3) chk("b2b_pat2", int'(pat_out_a), 4'b0100);
            if (second_k != 0 && k == second_k + 3) chk("b2b_pv2", int'(pat_valid_a), 1);
            prev_busy = busy_a;
        end
        code_valid = 1'b0;
        chk("b2b_spacing", second_k, 7);
        step();
        step();

        // Code changes and code_valid pulses while busy must be ignored.
        accept(2'd2);
        code  = 2'd0;
        rises = 0;
        prev_busy = busy_a;
        for (int k = 1; k <= 8; k++) begin
            code_valid = (k <= 5) ? k[0] : 1'b0;
            step();
            if (busy_a && !prev_busy) rises++;
            if (k == 3) chk("tog_pat", int'(pat_out_a), 4'b0100);
            prev_busy = busy_a;
        end
        chk("tog_extra_accepts", rises, 0);
        chk("tog_idle", int'(busy_a), 0);

        // Reset mid-SETUP after accepting code 2.
        accept(2'd2);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pat", int'(pat_out_a), 0);
        chk("mid_rst_pv", int'(pat_valid_a), 0);
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_ready", int'(code_ready_a), 1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (pat_valid_a || busy_a || dflt_pulse_a) saw_valid = 1'b1;
        end
        chk("mid_rst_no_update", int'(saw_valid), 0);
        chk("mid_rst_pat_after", int'(pat_out_a), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
